// File: rtl/fifo_pkg.sv
// fifo_pkg: shared definitions for the FIFO frame packer.
//   state_t         - packer FSM state encoding (IDLE, HDR, DATA, CSUM)
//   HDR_TAG_DEFAULT - default upper byte of the header word
//   RD_LAT          - upstream FIFO read latency in cycles
package fifo_pkg;
   typedef enum logic [1:0] {IDLE, HDR, DATA, CSUM} state_t;
   localparam logic [7:0] HDR_TAG_DEFAULT = 8'hA5;
   localparam int RD_LAT = 1;
endpackage

// File: rtl/frame_skid_buf.sv
// frame_skid_buf: 2-entry payload buffer between the FIFO read port and the stream output.
//   clk, rst_n       - clock, asynchronous active-low reset (empties the buffer)
//   push, push_data  - write one word (never issued while full)
//   pop              - drop the head word (never issued while empty)
//   head             - oldest buffered word
//   count            - number of occupied entries (0..2)
module frame_skid_buf #(
   parameter int DATA_W = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              push,
   input  logic [DATA_W-1:0] push_data,
   input  logic              pop,
   output logic [DATA_W-1:0] head,
   output logic [1:0]        count
);
   logic [DATA_W-1:0] mem [2];
   logic              wr_ptr;
   logic              rd_ptr;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mem[0] <= '0;
         mem[1] <= '0;
         wr_ptr <= 1'b0;
         rd_ptr <= 1'b0;
         count  <= 2'd0;
      end else begin
         if (push) begin
            mem[wr_ptr] <= push_data;
            wr_ptr      <= ~wr_ptr;
         end
         if (pop)
            rd_ptr <= ~rd_ptr;
         count <= count + 2'(push) - 2'(pop);
      end
   end

   assign head = mem[rd_ptr];
endmodule

// File: rtl/fifo_frame_packer.sv
// fifo_frame_packer: reads payload words from a synchronous FIFO and emits framed
// streams of header, FRAME_LEN payload words and a checksum word.
//   clk, rst_n            - clock, asynchronous active-low reset
//   fifo_empty, fifo_data - upstream FIFO status and read data (1-cycle latency)
//   fifo_r_en             - single-cycle read strobe to the upstream FIFO
//   m_valid, m_ready      - output stream handshake
//   m_data, m_last        - output word, high on the checksum word
//   frame_seq             - sequence number of the current or next frame
module fifo_frame_packer
   import fifo_pkg::*;
#(
   parameter int          DATA_W    = 16,
   parameter int          FRAME_LEN = 4,
   parameter logic [7:0]  HDR_TAG   = HDR_TAG_DEFAULT
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              fifo_empty,
   input  logic [DATA_W-1:0] fifo_data,
   output logic              fifo_r_en,
   output logic              m_valid,
   input  logic              m_ready,
   output logic [DATA_W-1:0] m_data,
   output logic              m_last,
   output logic [7:0]        frame_seq
);
   state_t            state;
   logic [7:0]        req_cnt;
   logic [7:0]        tx_cnt;
   logic [DATA_W-1:0] sum;
   logic [DATA_W-1:0] head;
   logic [1:0]        cnt;
   logic [RD_LAT-1:0] rd_pipe;
   logic              xfer;
   logic              pop;
   logic [2:0]        occ;

   frame_skid_buf #(.DATA_W(DATA_W)) u_buf (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (rd_pipe[RD_LAT-1]),
      .push_data (fifo_data),
      .pop       (pop),
      .head      (head),
      .count     (cnt)
   );

   // Outputs are decoded straight from registered state, so a reset clears them at once.
   assign m_valid = state == HDR || state == CSUM || (state == DATA && cnt != 2'd0);
   assign m_last  = state == CSUM;
   assign m_data  = state == HDR  ? DATA_W'({HDR_TAG, frame_seq}) :
                    state == DATA ? head :
                    state == CSUM ? sum : '0;
   assign xfer = m_valid && m_ready;
   assign pop  = xfer && state == DATA;

   // Occupancy counts the slot freed by this cycle's pop, which is what lets an
   // unstalled stream read and emit one payload word every cycle.
   assign occ = 3'(cnt) + 3'($countones(rd_pipe)) - 3'(pop);
   assign fifo_r_en = rst_n && !fifo_empty && req_cnt < 8'(FRAME_LEN) && occ < 3'd2;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         req_cnt   <= 8'd0;
         tx_cnt    <= 8'd0;
         sum       <= '0;
         frame_seq <= 8'd0;
         rd_pipe   <= '0;
      end else begin
         rd_pipe <= RD_LAT'({rd_pipe, fifo_r_en});
         if (fifo_r_en)
            req_cnt <= req_cnt + 8'd1;
         case (state)
            IDLE: if (!fifo_empty) state <= HDR;
            HDR:  if (xfer) state <= DATA;
            DATA: if (pop) begin
               sum    <= sum + head;
               tx_cnt <= tx_cnt + 8'd1;
               if (tx_cnt == 8'(FRAME_LEN - 1))
                  state <= CSUM;
            end
            CSUM: if (xfer) begin
               sum       <= '0;
               tx_cnt    <= 8'd0;
               req_cnt   <= 8'd0;
               frame_seq <= frame_seq + 8'd1;
               state     <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_fifo_frame_packer.sv
// tb_fifo_frame_packer: directed self-checking bench for fifo_frame_packer.
module tb_fifo_frame_packer;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        fifo_empty;
   logic [15:0] fifo_data = 16'h0;
   logic        fifo_r_en;
   logic        m_valid;
   logic        m_ready = 1'b0;
   logic [15:0] m_data;
   logic        m_last;
   logic [7:0]  frame_seq;

   logic [15:0] mem [0:4095];
   int          wr_idx = 0;
   int          rd_idx = 0;
   int          rd_pulses = 0;
   logic [16:0] out_q [$];
   int          errors = 0;
   int          checks = 0;

   fifo_frame_packer dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .fifo_empty (fifo_empty),
      .fifo_data  (fifo_data),
      .fifo_r_en  (fifo_r_en),
      .m_valid    (m_valid),
      .m_ready    (m_ready),
      .m_data     (m_data),
      .m_last     (m_last),
      .frame_seq  (frame_seq)
   );

   always #5 clk = ~clk;

   // Upstream synchronous FIFO with one-cycle read latency.
   assign fifo_empty = (rd_idx == wr_idx);
   always @(posedge clk) begin
      if (fifo_r_en) begin
         fifo_data <= mem[rd_idx];
         rd_idx    <= rd_idx + 1;
      end
   end

   always @(negedge clk) begin
      if (rst_n && m_valid && m_ready)
         out_q.push_back({m_last, m_data});
      if (fifo_r_en)
         rd_pulses++;
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic push(input logic [15:0] w);
      mem[wr_idx] = w;
      wr_idx++;
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic wait_out(input string tag, input int n);
      int i = 0;
      while (out_q.size() < n && i < 4000) begin
         tick(1);
         i++;
      end
      chk(tag, 32'(out_q.size() >= n), 32'd1);
   endtask

   task automatic chk_frame(input string tag, input logic [7:0] seq,
                            input logic [15:0] w0, input logic [15:0] w1,
                            input logic [15:0] w2, input logic [15:0] w3);
      logic [16:0] exp [6];
      logic [15:0] s;
      s = w0 + w1 + w2 + w3;
      exp[0] = {1'b0, 8'hA5, seq};
      exp[1] = {1'b0, w0};
      exp[2] = {1'b0, w1};
      exp[3] = {1'b0, w2};
      exp[4] = {1'b0, w3};
      exp[5] = {1'b1, s};
      wait_out({tag, "_len"}, 6);
      for (int i = 0; i < 6; i++)
         chk($sformatf("%s[%0d]", tag, i), 32'(out_q.size() > i ? out_q[i] : 17'h1ffff), 32'(exp[i]));
      for (int i = 0; i < 6; i++)
         if (out_q.size() > 0) void'(out_q.pop_front());
   endtask

   initial begin
      int held;
      int bad;
      int base;
      int r;
      push(16'h0001); push(16'h0002); push(16'h0003); push(16'h0004);
      tick(2);
      chk("rst_valid", 32'(m_valid), 32'd0);
      chk("rst_data", 32'(m_data), 32'd0);
      chk("rst_last", 32'(m_last), 32'd0);
      chk("rst_seq", 32'(frame_seq), 32'd0);
      chk("rst_ren", 32'(fifo_r_en), 32'd0);
      rst_n = 1'b1;
      m_ready = 1'b1;
      chk_frame("f0", 8'd0, 16'h0001, 16'h0002, 16'h0003, 16'h0004);
      tick(1);
      chk("seq1", 32'(frame_seq), 32'd1);

      push(16'hFFFF); push(16'hFFFF); push(16'h0002); push(16'h0000);
      chk_frame("f1", 8'd1, 16'hFFFF, 16'hFFFF, 16'h0002, 16'h0000);

      // Downstream stall in the middle of the payload.
      push(16'h0010); push(16'h0020); push(16'h0030); push(16'h0040);
      wait_out("stall_start", 2);
      m_ready = 1'b0;
      base = rd_pulses;
      @(negedge clk);
      held = 32'(m_data);
      chk("stall_valid", 32'(m_valid), 32'd1);
      bad = 0;
      repeat (10) begin
         @(negedge clk);
         if (32'(m_data) != held || !m_valid) bad++;
      end
      chk("stall_hold", bad, 0);
      chk("stall_reads", 32'(rd_pulses - base <= 2), 32'd1);
      @(posedge clk); #1;
      m_ready = 1'b1;
      chk_frame("f2", 8'd2, 16'h0010, 16'h0020, 16'h0030, 16'h0040);

      // Upstream runs dry after the second payload word.
      push(16'h0100); push(16'h0200);
      wait_out("gap_start", 3);
      bad = 0;
      repeat (5) begin
         @(negedge clk);
         if (m_valid || fifo_r_en || !fifo_empty) bad++;
      end
      chk("gap_idle", bad, 0);
      push(16'h0300); push(16'h0400);
      chk_frame("f3", 8'd3, 16'h0100, 16'h0200, 16'h0300, 16'h0400);

      // Reset in the middle of a frame.
      for (int i = 1; i <= 8; i++) push(16'(i * 16'h0011));
      wait_out("rst_start", 2);
      rst_n = 1'b0;
      #1;
      chk("mrst_valid", 32'(m_valid), 32'd0);
      chk("mrst_data", 32'(m_data), 32'd0);
      chk("mrst_last", 32'(m_last), 32'd0);
      chk("mrst_seq", 32'(frame_seq), 32'd0);
      chk("mrst_ren", 32'(fifo_r_en), 32'd0);
      out_q.delete();
      tick(2);
      r = rd_idx;
      rst_n = 1'b1;
      chk_frame("f_rst", 8'd0, mem[r], mem[r + 1], mem[r + 2], mem[r + 3]);

      // Clean restart, then 257 back-to-back frames to wrap the sequence number.
      rst_n = 1'b0;
      tick(1);
      wr_idx = rd_idx;
      out_q.delete();
      tick(1);
      rst_n = 1'b1;
      for (int i = 0; i < 257 * 4; i++) push(16'(i));
      wait_out("b2b_len", 257 * 6);
      bad = 0;
      for (int f = 0; f < 257 && out_q.size() >= 257 * 6; f++)
         if (out_q[f * 6] !== {1'b0, 8'hA5, 8'(f)} || out_q[f * 6 + 5][16] !== 1'b1) bad++;
      chk("b2b_hdrs", bad, 0);
      chk("hdr256", 32'(out_q.size() > 255 * 6 ? out_q[255 * 6] : 17'h1ffff), 32'h0A5FF);
      chk("hdr257", 32'(out_q.size() > 256 * 6 ? out_q[256 * 6] : 17'h1ffff), 32'h0A500);
      tick(2);
      chk("seq_wrap", 32'(frame_seq), 32'd1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
